ofifo_drain: RTL and testbench

//  Reader for the corelet output FIFO (OFIFO). Pops column psum words once OFIFO shows valid data.

---
 rtl/ofifo_drain.sv | 168 ++++++++++++++++
 tb/tb_ofifo_drain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_drain.sv
// ofifo_drain: drains column psum words from the corelet OFIFO into the psum SRAM.
// Overwrite mode writes each word at base_addr+k. Accumulate mode reads the stored
// psum first, adds the OFIFO word lane-wise, then writes the sum back.
// Build option: define ACC_SAT_EN to make the accumulate add saturate per lane.
// Without it, the accumulate add wraps modulo 2^psum_bw.

// One signed psum lane of the accumulate adder.
module ofifo_drain_lane #(
   parameter int psum_bw = 16
) (
   input  logic [psum_bw-1:0] a,
   input  logic [psum_bw-1:0] b,
   output logic [psum_bw-1:0] sum
);
`ifdef ACC_SAT_EN
   logic [psum_bw:0] full;

   // Sign-extended add. An overflow clamps to the nearest representable bound.
   always_comb begin
      full = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (full[psum_bw] != full[psum_bw-1])
         sum = full[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      else
         sum = full[psum_bw-1:0];
   end
`else
   assign sum = a + b;
`endif
endmodule

module ofifo_drain #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_bw = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     acc_mode,
   input  logic [addr_bw-1:0]       base_addr,
   input  logic [addr_bw-1:0]       num_words,
   input  logic                     ofifo_o_valid,
   input  logic [col*psum_bw-1:0]   ofifo_out,
   output logic                     ofifo_rd,
   input  logic [col*psum_bw-1:0]   psum_q,
   output logic                     psum_cen,
   output logic                     psum_wen,
   output logic [addr_bw-1:0]       psum_a,
   output logic [col*psum_bw-1:0]   psum_d,
   output logic                     busy,
   output logic                     done
);
   localparam int W = col * psum_bw;

   typedef enum logic [2:0] {IDLE, POP, GAP, RD_REQ, RD_WAIT, WR, FIN} state_t;

   state_t             state, state_n;
   logic               acc_q, acc_n;
   logic [addr_bw-1:0] base_q, base_n, num_q, num_n, k_q, k_n;
   logic [addr_bw-1:0] cur_addr, k_inc;
   logic               rd_n, cen_n, wen_n, busy_n, done_n;
   logic [addr_bw-1:0] a_n;
   logic [W-1:0]       d_n, acc_sum;

   // The address wraps silently at 2^addr_bw.
   assign cur_addr = base_q + k_q;
   assign k_inc    = k_q + addr_bw'(1);

   for (genvar i = 0; i < col; i++) begin : g_lane
      ofifo_drain_lane #(.psum_bw(psum_bw)) u_lane (
         .a   (psum_q[i*psum_bw +: psum_bw]),
         .b   (ofifo_out[i*psum_bw +: psum_bw]),
         .sum (acc_sum[i*psum_bw +: psum_bw])
      );
   end

   // Next state, job fields and registered SRAM/OFIFO strobes.
   always_comb begin
      state_n = state;
      acc_n   = acc_q;
      base_n  = base_q;
      num_n   = num_q;
      k_n     = k_q;
      rd_n    = 1'b0;
      cen_n   = 1'b1;
      wen_n   = 1'b1;
      a_n     = psum_a;
      d_n     = psum_d;
      busy_n  = busy;
      unique case (state)
         IDLE: if (start) begin
            acc_n  = acc_mode;
            base_n = base_addr;
            num_n  = num_words;
            k_n    = '0;
            busy_n = 1'b1;
            if (num_words == '0) state_n = FIN;
            else                 state_n = acc_mode ? RD_REQ : POP;
         end
         POP: if (ofifo_o_valid) begin
            rd_n    = 1'b1;
            cen_n   = 1'b0;
            wen_n   = 1'b0;
            a_n     = cur_addr;
            d_n     = ofifo_out;
            state_n = GAP;
         end
         // Bubble so the pop lands before valid is looked at again.
         GAP: begin
            k_n     = k_inc;
            state_n = (k_inc == num_q) ? FIN : POP;
         end
         RD_REQ: if (ofifo_o_valid) begin
            cen_n   = 1'b0;
            a_n     = cur_addr;
            state_n = RD_WAIT;
         end
         RD_WAIT: state_n = WR;
         WR: begin
            rd_n    = 1'b1;
            cen_n   = 1'b0;
            wen_n   = 1'b0;
            a_n     = cur_addr;
            d_n     = acc_sum;
            k_n     = k_inc;
            state_n = (k_inc == num_q) ? FIN : (acc_q ? RD_REQ : POP);
         end
         FIN: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Entering FIN raises done, so it is high for the single FIN cycle.
      done_n = (state_n == FIN);
   end

   // State, job fields and all outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         acc_q    <= 1'b0;
         base_q   <= '0;
         num_q    <= '0;
         k_q      <= '0;
         ofifo_rd <= 1'b0;
         psum_cen <= 1'b1;
         psum_wen <= 1'b1;
         psum_a   <= '0;
         psum_d   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         acc_q    <= acc_n;
         base_q   <= base_n;
         num_q    <= num_n;
         k_q      <= k_n;
         ofifo_rd <= rd_n;
         psum_cen <= cen_n;
         psum_wen <= wen_n;
         psum_a   <= a_n;
         psum_d   <= d_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end
endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain with a behavioural OFIFO and psum SRAM.
module tb_ofifo_drain;
   localparam int COL = 8, PBW = 16, ABW = 11, W = COL * PBW;

   logic           clk = 1'b0, reset = 1'b0, start = 1'b0, acc_mode = 1'b0;
   logic [ABW-1:0] base_addr = '0, num_words = '0;
   logic           ofifo_o_valid, ofifo_rd, psum_cen, psum_wen, busy, done;
   logic [W-1:0]   ofifo_out, psum_q, psum_d;
   logic [ABW-1:0] psum_a;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   ofifo_drain #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
      .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
      .base_addr(base_addr), .num_words(num_words),
      .ofifo_o_valid(ofifo_o_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
      .psum_q(psum_q), .psum_cen(psum_cen), .psum_wen(psum_wen),
      .psum_a(psum_a), .psum_d(psum_d), .busy(busy), .done(done)
   );

   // OFIFO model: pushed by the stimulus, popped on ofifo_rd
   logic [W-1:0] fq [32];
   int wp = 0, rp = 0;
   assign ofifo_o_valid = (wp != rp);
   assign ofifo_out     = fq[rp[4:0]];

   // SRAM model: one-cycle read latency
   logic [W-1:0] mem [2048];
   always @(posedge clk)
      if (!psum_cen) begin
         if (!psum_wen) mem[psum_a] <= psum_d;
         else           psum_q      <= mem[psum_a];
      end

   // Monitor: logs SRAM accesses, pops and done pulses with cycle stamps
   int cyc = 0, nwr = 0, nrd = 0, nacc = 0, done_cnt = 0, done_t = 0, pops = 0, pop_bad = 0;
   logic [ABW-1:0] wr_a [256];
   logic [ABW-1:0] rd_a [256];
   logic [W-1:0]   wr_d [256];
   int             wr_t [256];
   int             rd_t [256];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!psum_cen) begin
         nacc <= nacc + 1;
         if (!psum_wen) begin
            wr_a[nwr] <= psum_a; wr_d[nwr] <= psum_d; wr_t[nwr] <= cyc; nwr <= nwr + 1;
         end else begin
            rd_a[nrd] <= psum_a; rd_t[nrd] <= cyc; nrd <= nrd + 1;
         end
      end
      if (done) begin done_cnt <= done_cnt + 1; done_t <= cyc; end
      if (ofifo_rd) begin
         pops <= pops + 1;
         if (wp == rp) pop_bad <= pop_bad + 1;
         else          rp <= rp + 1;
      end
   end

   function automatic logic [W-1:0] mk(input logic [15:0] l0, input logic [15:0] rest);
      logic [W-1:0] w;
      w = {COL{rest}};
      w[15:0] = l0;
      return w;
   endfunction

   task automatic push(input logic [W-1:0] w);
      fq[wp[4:0]] = w;
      wp = wp + 1;
   endtask

   task automatic kick(input logic acc, input logic [ABW-1:0] b, input logic [ABW-1:0] n, output int s);
      @(negedge clk);
      s = cyc; start = 1'b1; acc_mode = acc; base_addr = b; num_words = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_cnt > d0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({ofifo_rd, psum_cen, psum_wen, busy, done} !== 5'b01100) begin n_bad++; $display("FAIL reset_strobes got %b want 01100", {ofifo_rd, psum_cen, psum_wen, busy, done}); end
      n_cmp++; if (psum_a !== 11'h000) begin n_bad++; $display("FAIL reset_a got %h want 000", psum_a); end
      n_cmp++; if (psum_d !== '0) begin n_bad++; $display("FAIL reset_d got %h want 0", psum_d); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_job;
      int s, d0, w0;
      d0 = done_cnt; w0 = nwr;
      push(mk(16'h0001, 16'h0001)); push(mk(16'h0002, 16'h0002));
      kick(1'b1, 11'h070, 11'd2, s);
      repeat (2) @(negedge clk);           // now in the WR cycle
      reset = 1'b0;
      #1;
      n_cmp++; if ({ofifo_rd, psum_cen, psum_wen, busy, done} !== 5'b01100) begin n_bad++; $display("FAIL midreset_strobes got %b want 01100", {ofifo_rd, psum_cen, psum_wen, busy, done}); end
      n_cmp++; if (psum_a !== 11'h000) begin n_bad++; $display("FAIL midreset_a got %h want 000", psum_a); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wp = rp;
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
      n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL midreset_done got %0d want %0d", done_cnt, d0); end
      n_cmp++; if (nwr !== w0) begin n_bad++; $display("FAIL midreset_writes got %0d want %0d", nwr, w0); end
   endtask

   task automatic test_overwrite;
      int s, d0, w0, p0; bit ok;
      logic [W-1:0] wd [4];
      d0 = done_cnt; w0 = nwr; p0 = pops;
      for (int i = 0; i < 4; i++) begin wd[i] = mk(16'h1000 + 16'(i), 16'h2000 + 16'(i)); push(wd[i]); end
      kick(1'b0, 11'h010, 11'd4, s);
      wait_done(d0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovw_timeout got no done want done"); end
      n_cmp++; if (nwr - w0 !== 4) begin n_bad++; $display("FAIL ovw_count got %0d want 4", nwr - w0); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (wr_a[w0+i] !== 11'(16 + i)) begin n_bad++; $display("FAIL ovw_addr%0d got %h want %h", i, wr_a[w0+i], 11'(16 + i)); end
         n_cmp++; if (wr_d[w0+i] !== wd[i]) begin n_bad++; $display("FAIL ovw_data%0d got %h want %h", i, wr_d[w0+i], wd[i]); end
         n_cmp++; if (wr_t[w0+i] !== s + 2 + 2*i) begin n_bad++; $display("FAIL ovw_time%0d got %0d want %0d", i, wr_t[w0+i], s + 2 + 2*i); end
      end
      n_cmp++; if (pops - p0 !== 4) begin n_bad++; $display("FAIL ovw_pops got %0d want 4", pops - p0); end
      n_cmp++; if (done_t !== s + 9) begin n_bad++; $display("FAIL ovw_done_time got %0d want %0d", done_t, s + 9); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovw_busy got %b want 0", busy); end
   endtask

   task automatic test_accumulate;
      int s, d0, w0, r0; bit ok;
      d0 = done_cnt;
      push(mk(16'd100, 16'd100));
      kick(1'b0, 11'h005, 11'd1, s);
      wait_done(d0, ok);
      d0 = done_cnt; w0 = nwr; r0 = nrd;
      push(mk(16'hFFE2, 16'hFFE2));        // -30 in every lane
      kick(1'b1, 11'h005, 11'd1, s);
      wait_done(d0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL acc_timeout got no done want done"); end
      n_cmp++; if (rd_a[r0] !== 11'h005) begin n_bad++; $display("FAIL acc_rd_addr got %h want 005", rd_a[r0]); end
      n_cmp++; if (wr_a[w0] !== 11'h005) begin n_bad++; $display("FAIL acc_wr_addr got %h want 005", wr_a[w0]); end
      n_cmp++; if (wr_d[w0] !== mk(16'd70, 16'd70)) begin n_bad++; $display("FAIL acc_data got %h want %h", wr_d[w0], mk(16'd70, 16'd70)); end
      n_cmp++; if (wr_t[w0] - rd_t[r0] !== 2) begin n_bad++; $display("FAIL acc_rd_to_wr got %0d want 2", wr_t[w0] - rd_t[r0]); end
      n_cmp++; if (mem[5] !== mk(16'd70, 16'd70)) begin n_bad++; $display("FAIL acc_mem got %h want %h", mem[5], mk(16'd70, 16'd70)); end
   endtask

   task automatic test_saturation;
      int s, d0, w0; bit ok;
      logic [15:0] e0, e1;
`ifdef ACC_SAT_EN
      e0 = 16'h7FFF; e1 = 16'h8000;
`else
      e0 = 16'h8010; e1 = 16'h7FF0;
`endif
      d0 = done_cnt;
      push(mk(16'h7FF0, 16'h0001)); push(mk(16'h8010, 16'h0001));
      kick(1'b0, 11'h020, 11'd2, s);
      wait_done(d0, ok);
      d0 = done_cnt; w0 = nwr;
      push(mk(16'h0020, 16'h0001)); push(mk(16'hFFE0, 16'h0001));
      kick(1'b1, 11'h020, 11'd2, s);
      wait_done(d0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sat_timeout got no done want done"); end
      n_cmp++; if (wr_d[w0] !== mk(e0, 16'h0002)) begin n_bad++; $display("FAIL sat_pos got %h want %h", wr_d[w0], mk(e0, 16'h0002)); end
      n_cmp++; if (wr_d[w0+1] !== mk(e1, 16'h0002)) begin n_bad++; $display("FAIL sat_neg got %h want %h", wr_d[w0+1], mk(e1, 16'h0002)); end
      n_cmp++; if (wr_a[w0+1] !== 11'h021) begin n_bad++; $display("FAIL sat_addr got %h want 021", wr_a[w0+1]); end
      n_cmp++; if (wr_t[w0+1] - wr_t[w0] !== 3) begin n_bad++; $display("FAIL acc_rate got %0d want 3", wr_t[w0+1] - wr_t[w0]); end
   endtask

   task automatic test_stall;
      int s, d0, w0, p0, pa, ca; bit ok;
      d0 = done_cnt; w0 = nwr; p0 = pops;
      push(mk(16'h3000, 16'h3100));
      kick(1'b0, 11'h040, 11'd3, s);
      repeat (4) @(negedge clk);
      pa = pops; ca = nacc;
      repeat (10) @(negedge clk);
      n_cmp++; if (pops !== pa) begin n_bad++; $display("FAIL stall_pops got %0d want %0d", pops, pa); end
      n_cmp++; if (nacc !== ca) begin n_bad++; $display("FAIL stall_sram got %0d want %0d", nacc, ca); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy got %b want 1", busy); end
      push(mk(16'h3001, 16'h3101)); push(mk(16'h3002, 16'h3102));
      wait_done(d0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_timeout got no done want done"); end
      n_cmp++; if (wr_a[w0+1] !== 11'h041) begin n_bad++; $display("FAIL stall_addr1 got %h want 041", wr_a[w0+1]); end
      n_cmp++; if (wr_a[w0+2] !== 11'h042) begin n_bad++; $display("FAIL stall_addr2 got %h want 042", wr_a[w0+2]); end
      n_cmp++; if (wr_d[w0+2] !== mk(16'h3002, 16'h3102)) begin n_bad++; $display("FAIL stall_data got %h want %h", wr_d[w0+2], mk(16'h3002, 16'h3102)); end
      n_cmp++; if (pops - p0 !== 3) begin n_bad++; $display("FAIL stall_popcnt got %0d want 3", pops - p0); end
   endtask

   task automatic test_corners;
      int s, s2, d0, w0, c0; bit ok;
      // zero-length job
      d0 = done_cnt; c0 = nacc;
      kick(1'b0, 11'h100, 11'd0, s);
      wait_done(d0, ok);
      n_cmp++; if (done_t !== s + 1) begin n_bad++; $display("FAIL zero_done_time got %0d want %0d", done_t, s + 1); end
      n_cmp++; if (nacc !== c0) begin n_bad++; $display("FAIL zero_sram got %0d want %0d", nacc, c0); end
      // start while busy is ignored
      d0 = done_cnt; w0 = nwr;
      kick(1'b0, 11'h050, 11'd2, s);
      repeat (3) @(negedge clk);
      kick(1'b0, 11'h060, 11'd1, s2);
      push(mk(16'h5000, 16'h5000)); push(mk(16'h5001, 16'h5001));
      wait_done(d0, ok);
      repeat (6) @(negedge clk);
      n_cmp++; if (nwr - w0 !== 2) begin n_bad++; $display("FAIL busy_start_writes got %0d want 2", nwr - w0); end
      n_cmp++; if (wr_a[w0+1] !== 11'h051) begin n_bad++; $display("FAIL busy_start_addr got %h want 051", wr_a[w0+1]); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL busy_start_done got %0d want 1", done_cnt - d0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle got %b want 0", busy); end
      // address wrap
      d0 = done_cnt; w0 = nwr;
      push(mk(16'h6000, 16'h6000)); push(mk(16'h6001, 16'h6001));
      kick(1'b0, 11'h7FF, 11'd2, s);
      wait_done(d0, ok);
      n_cmp++; if (wr_a[w0] !== 11'h7FF) begin n_bad++; $display("FAIL wrap_addr0 got %h want 7ff", wr_a[w0]); end
      n_cmp++; if (wr_a[w0+1] !== 11'h000) begin n_bad++; $display("FAIL wrap_addr1 got %h want 000", wr_a[w0+1]); end
      n_cmp++; if (pop_bad !== 0) begin n_bad++; $display("FAIL empty_pops got %0d want 0", pop_bad); end
   endtask

   initial begin
      test_reset;
      test_reset_mid_job;
      test_overwrite;
      test_accumulate;
      test_saturation;
      test_stall;
      test_corners;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
